pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Controls the system PLL (50 MHz ref → 18/12/24 MHz outputs) from the 50 MHz reference domain.
- Pulses the PLL reset, waits for lock and qualifies that lock as stable, then releases the downstream system reset.
- Retries with a timeout, and restarts the sequence on lock loss or on a user reconfigure request.
- Sits between the board clock input and the core reset tree, in front of per-domain reset synchronisers.

Parameters:
- RST_HOLD_CYCLES, 16: refclk cycles pll_rst is held high per attempt (≥1).
- LOCK_STABLE_CYCLES, 1024: consecutive synced-locked-high cycles required before ready.
- LOCK_TIMEOUT_CYCLES, 500000: cycles allowed from pll_rst release to stable lock (10 ms at 50 MHz).
- MAX_RETRIES, 3: automatic re-attempts after a timeout before declaring failure (≤255).

Ports:
- refclk, in, 1: 50 MHz reference clock; the only clock.
- rst, in, 1: synchronous, active-high reset.
- req_reconfig, in, 1: single-cycle pulse requesting a full PLL restart.
- pll_locked, in, 1: PLL lock, asynchronous to refclk.
- pll_rst, out, 1: PLL reset, active-high.
- sys_reset, out, 1: downstream core reset, active-high.
- ready, out, 1: PLL locked and qualified; equals ~sys_reset & ~fail.
- fail, out, 1: retries exhausted.
- state_dbg, out, 3: current FSM state encoding.
- retry_cnt, out, 8: attempts consumed since last rst/req_reconfig.

Behaviour:
- Reset (rst=1): state=S_RESET, hold counter=0, pll_rst=1, sys_reset=1, ready=0, fail=0, retry_cnt=0, timeout counter=0, stable counter=0. All outputs are registered.
- Lock synchroniser: pll_locked passes through a 2-flop synchroniser to give locked_s. Latency is 2 cycles. The FSM uses only locked_s.
- S_RESET:
  - pll_rst=1, sys_reset=1. Hold counter increments each cycle.
  - When hold counter = RST_HOLD_CYCLES-1 → S_WAIT_LOCK; clear the timeout counter.
  - pll_rst is therefore high for exactly RST_HOLD_CYCLES cycles after rst falls.
- S_WAIT_LOCK:
  - pll_rst=0, sys_reset=1. Timeout counter increments.
  - locked_s=1 → S_STABLE; stable counter=1.
- S_STABLE:
  - pll_rst=0, sys_reset=1. Timeout counter keeps counting.
  - locked_s=1: stable counter increments. On reaching LOCK_STABLE_CYCLES → S_RUN.
  - locked_s=0 → S_WAIT_LOCK; stable counter=0; timeout counter is not cleared.
- Timeout (S_WAIT_LOCK or S_STABLE), when the timeout counter reaches LOCK_TIMEOUT_CYCLES-1:
  - retry_cnt < MAX_RETRIES → retry_cnt+1, then S_RESET.
  - otherwise → S_FAIL.
- S_RUN:
  - pll_rst=0, sys_reset=0, ready=1. Remains here while locked_s=1.
  - locked_s=0 → S_RESET; sys_reset=1 on the next cycle. retry_cnt is cleared (lock loss is a fresh attempt, not a retry).
- S_FAIL:
  - pll_rst=1, sys_reset=1, fail=1. Sticky; exits only on rst or req_reconfig.
- req_reconfig:
  - Honoured in every state, including mid-S_RESET, where the hold count restarts at 0.
  - Effect: S_RESET, clear retry_cnt, clear all counters, fail=0.
  - Priority: rst > req_reconfig > timeout > lock events.
  - Timeout and locked_s falling in the same cycle: the timeout wins.
- Counters: widths are $clog2(max+1). All counters saturate, never wrap.
- ready rises LOCK_STABLE_CYCLES cycles after locked_s first rises, provided there is no dropout.
- State encoding (state_dbg): S_RESET=0, S_WAIT_LOCK=1, S_STABLE=2, S_RUN=3, S_FAIL=4.

Decomposition:
- Shared package pll_seq_pkg holds:
  - the state enum and its 3-bit encoding;
  - default timing constants;
  - a cycles-from-µs helper constant for a 50 MHz refclk.
- One sub-module: sync_2ff, a generic 2-flop synchroniser reusable across the core.

Test Plan:
Bench parameters: RST_HOLD=4, LOCK_STABLE=8, TIMEOUT=64, MAX_RETRIES=2.
- Nominal: release rst, drive pll_locked=1 from cycle 10 → pll_rst high for cycles 0-3; ready/sys_reset=0 at cycle 10+2+8; retry_cnt=0.
- Lock glitch: pll_locked high 5 cycles, low 1, high again → ready delayed by 8 cycles from the second rise; no retry unless 64 cycles have elapsed.
- Never lock: pll_locked=0 → three pll_rst pulses (retry_cnt 0,1,2) each 4 cycles, spaced 64+4; then fail=1, state_dbg=4, pll_rst=1 held.
- Lock loss in RUN: drop pll_locked → sys_reset=1 within 3 cycles; pll_rst pulse of 4 cycles; ready returns after re-lock+8; retry_cnt=0.
- req_reconfig from S_FAIL and mid-S_STABLE → immediate S_RESET; fail=0; retry_cnt=0; full sequence repeats.
- rst mid-S_STABLE → all outputs at reset values the next cycle; the sequence restarts from S_RESET.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared state encoding and timing defaults for the PLL reset sequencer.
// All timing values are expressed in 50 MHz reference clock cycles.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      S_RESET     = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAIL      = 3'd4
   } state_t;

   localparam int unsigned REFCLK_CYCLES_PER_US = 50;

   function automatic int unsigned us_to_cycles(input int unsigned us);
      return us * REFCLK_CYCLES_PER_US;
   endfunction

   localparam int unsigned DEF_RST_HOLD_CYCLES     = 16;
   localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
   localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = us_to_cycles(10_000);
   localparam int unsigned DEF_MAX_RETRIES         = 3;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for bringing asynchronous levels into clk.
// Output lags the input by two clk edges.
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // NOTE: non-blocking assignments make both stages sample on the same edge;
   // blocking ones would collapse the chain into a single flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Pulses the PLL reset, qualifies lock, then releases the downstream reset.
// Retries on timeout, restarts on lock loss or on a reconfigure request.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
   parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
   parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       req_reconfig,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_reset,
   output logic       ready,
   output logic       fail,
   output logic [2:0] state_dbg,
   output logic [7:0] retry_cnt
);

   localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
   localparam int STAB_W = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam int TMO_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(LOCK_STABLE_CYCLES);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [7:0]        RETRY_MAX = 8'(MAX_RETRIES);

   logic locked_s;

   state_t            state_q, state_n;
   logic [HOLD_W-1:0] hold_q, hold_n;
   logic [STAB_W-1:0] stab_q, stab_n;
   logic [TMO_W-1:0]  tmo_q, tmo_n;
   logic [7:0]        retry_q, retry_n;

   sync_2ff #(.WIDTH(1)) u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked),
      .q   (locked_s)
   );

   // NOTE: every variable gets its default before the case so that no path
   // leaves one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_n = state_q;
      hold_n  = hold_q;
      stab_n  = stab_q;
      tmo_n   = tmo_q;
      retry_n = retry_q;

      if (req_reconfig) begin
         state_n = S_RESET;
         hold_n  = '0;
         stab_n  = '0;
         tmo_n   = '0;
         retry_n = '0;
      end else begin
         case (state_q)
            S_RESET: begin
               stab_n = '0;
               tmo_n  = '0;
               if (hold_q >= HOLD_LAST) begin
                  state_n = S_WAIT_LOCK;
                  hold_n  = '0;
               end else begin
                  hold_n = hold_q + 1'b1;
               end
            end

            S_WAIT_LOCK, S_STABLE: begin
               hold_n = '0;
               // Timeout outranks any lock event seen in the same cycle.
               if (tmo_q >= TMO_LAST) begin
                  stab_n = '0;
                  tmo_n  = '0;
                  if (retry_q < RETRY_MAX) begin
                     retry_n = retry_q + 1'b1;
                     state_n = S_RESET;
                  end else begin
                     state_n = S_FAIL;
                  end
               end else begin
                  tmo_n = tmo_q + 1'b1;
                  if (!locked_s) begin
                     state_n = S_WAIT_LOCK;
                     stab_n  = '0;
                  end else if (state_q == S_WAIT_LOCK) begin
                     stab_n  = STAB_W'(1);
                     state_n = (LOCK_STABLE_CYCLES <= 1) ? S_RUN : S_STABLE;
                  end else if (stab_q >= STAB_LAST) begin
                     stab_n  = STAB_MAX;
                     state_n = S_RUN;
                  end else begin
                     stab_n = stab_q + 1'b1;
                  end
               end
            end

            S_RUN: begin
               hold_n = '0;
               tmo_n  = '0;
               // Lock loss is a fresh attempt, so the retry budget is restored.
               if (!locked_s) begin
                  state_n = S_RESET;
                  stab_n  = '0;
                  retry_n = '0;
               end
            end

            S_FAIL: begin
               hold_n = '0;
               stab_n = '0;
               tmo_n  = '0;
            end

            default: begin
               state_n = S_RESET;
               hold_n  = '0;
               stab_n  = '0;
               tmo_n   = '0;
               retry_n = '0;
            end
         endcase
      end
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q   <= S_RESET;
         hold_q    <= '0;
         stab_q    <= '0;
         tmo_q     <= '0;
         retry_q   <= '0;
         pll_rst   <= 1'b1;
         sys_reset <= 1'b1;
         ready     <= 1'b0;
         fail      <= 1'b0;
      end else begin
         state_q   <= state_n;
         hold_q    <= hold_n;
         stab_q    <= stab_n;
         tmo_q     <= tmo_n;
         retry_q   <= retry_n;
         pll_rst   <= (state_n == S_RESET) || (state_n == S_FAIL);
         sys_reset <= (state_n != S_RUN);
         ready     <= (state_n == S_RUN);
         fail      <= (state_n == S_FAIL);
      end
   end

   assign state_dbg = state_q;
   assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: table-driven timelines plus
// hand-written retry/fail and mid-sequence reset scenarios.
module tb_pll_reset_sequencer;
   import pll_seq_pkg::*;

   localparam int RST_HOLD    = 4;
   localparam int LOCK_STABLE = 8;
   localparam int TIMEOUT     = 64;
   localparam int MAX_RETRIES = 2;
   localparam int PERIOD      = RST_HOLD + TIMEOUT;
   localparam int FAIL_CYC    = (MAX_RETRIES + 1) * PERIOD;

   logic       refclk;
   logic       rst;
   logic       req_reconfig;
   logic       pll_locked;
   logic       pll_rst;
   logic       sys_reset;
   logic       ready;
   logic       fail;
   logic [2:0] state_dbg;
   logic [7:0] retry_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      int          cyc;
      logic        locked;
      logic        reconfig;
      state_t      exp_state;
      logic [7:0]  exp_retry;
   } vec_t;

   vec_t tbl[$];

   pll_reset_sequencer #(
      .RST_HOLD_CYCLES     (RST_HOLD),
      .LOCK_STABLE_CYCLES  (LOCK_STABLE),
      .LOCK_TIMEOUT_CYCLES (TIMEOUT),
      .MAX_RETRIES         (MAX_RETRIES)
   ) dut (
      .refclk       (refclk),
      .rst          (rst),
      .req_reconfig (req_reconfig),
      .pll_locked   (pll_locked),
      .pll_rst      (pll_rst),
      .sys_reset    (sys_reset),
      .ready        (ready),
      .fail         (fail),
      .state_dbg    (state_dbg),
      .retry_cnt    (retry_cnt)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   task automatic tick();
      @(posedge refclk);
      #1;
      cyc++;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected output levels follow from the state the sequencer should be in.
   task automatic check_outputs(input string tag, input state_t st, input logic [7:0] rt);
      check({tag, " state_dbg"}, 32'(state_dbg), 32'(st));
      check({tag, " retry_cnt"}, 32'(retry_cnt), 32'(rt));
      check({tag, " pll_rst"},   32'(pll_rst),   32'((st == S_RESET) || (st == S_FAIL)));
      check({tag, " sys_reset"}, 32'(sys_reset), 32'(st != S_RUN));
      check({tag, " ready"},     32'(ready),     32'(st == S_RUN));
      check({tag, " fail"},      32'(fail),      32'(st == S_FAIL));
   endtask

   function automatic vec_t mk(input int c, input logic lk, input logic rc,
                               input state_t st, input logic [7:0] rt);
      vec_t v;
      v.cyc = c; v.locked = lk; v.reconfig = rc; v.exp_state = st; v.exp_retry = rt;
      return v;
   endfunction

   // Cycle 0 is the first cycle with rst low; inputs driven at cycle c are
   // first sampled by the edge that ends cycle c.
   task automatic do_reset();
      rst          = 1'b1;
      req_reconfig = 1'b0;
      pll_locked   = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic run_table(input string tag);
      foreach (tbl[i]) begin
         while (cyc < tbl[i].cyc) tick();
         check_outputs($sformatf("%s c%0d", tag, cyc), tbl[i].exp_state, tbl[i].exp_retry);
         pll_locked   = tbl[i].locked;
         req_reconfig = tbl[i].reconfig;
      end
      tbl.delete();
   endtask

   initial begin
      logic exp_pr;
      rst          = 1'b1;
      req_reconfig = 1'b0;
      pll_locked   = 1'b0;

      // Nominal bring-up, then lock loss while running.
      do_reset();
      tbl.push_back(mk( 0, 1'b0, 1'b0, S_RESET,     8'd0));
      tbl.push_back(mk( 3, 1'b0, 1'b0, S_RESET,     8'd0));
      tbl.push_back(mk( 4, 1'b0, 1'b0, S_WAIT_LOCK, 8'd0));
      tbl.push_back(mk(10, 1'b1, 1'b0, S_WAIT_LOCK, 8'd0));
      tbl.push_back(mk(12, 1'b1, 1'b0, S_WAIT_LOCK, 8'd0));
      tbl.push_back(mk(13, 1'b1, 1'b0, S_STABLE,    8'd0));
      tbl.push_back(mk(19, 1'b1, 1'b0, S_STABLE,    8'd0));
      tbl.push_back(mk(20, 1'b1, 1'b0, S_RUN,       8'd0));
      tbl.push_back(mk(30, 1'b0, 1'b0, S_RUN,       8'd0));
      tbl.push_back(mk(32, 1'b0, 1'b0, S_RUN,       8'd0));
      tbl.push_back(mk(33, 1'b0, 1'b0, S_RESET,     8'd0));
      tbl.push_back(mk(36, 1'b0, 1'b0, S_RESET,     8'd0));
      tbl.push_back(mk(37, 1'b0, 1'b0, S_WAIT_LOCK, 8'd0));
      tbl.push_back(mk(40, 1'b1, 1'b0, S_WAIT_LOCK, 8'd0));
      tbl.push_back(mk(49, 1'b1, 1'b0, S_STABLE,    8'd0));
      tbl.push_back(mk(50, 1'b1, 1'b0, S_RUN,       8'd0));
      run_table("nominal");

      // One-cycle lock dropout during qualification.
      do_reset();
      tbl.push_back(mk( 0, 1'b0, 1'b0, S_RESET,     8'd0));
      tbl.push_back(mk(10, 1'b1, 1'b0, S_WAIT_LOCK, 8'd0));
      tbl.push_back(mk(15, 1'b0, 1'b0, S_STABLE,    8'd0));
      tbl.push_back(mk(16, 1'b1, 1'b0, S_STABLE,    8'd0));
      tbl.push_back(mk(17, 1'b1, 1'b0, S_STABLE,    8'd0));
      tbl.push_back(mk(18, 1'b1, 1'b0, S_WAIT_LOCK, 8'd0));
      tbl.push_back(mk(19, 1'b1, 1'b0, S_STABLE,    8'd0));
      tbl.push_back(mk(25, 1'b1, 1'b0, S_STABLE,    8'd0));
      tbl.push_back(mk(26, 1'b1, 1'b0, S_RUN,       8'd0));
      run_table("glitch");

      // Timeout coinciding with a dropout, a retried lock, then lock loss.
      do_reset();
      tbl.push_back(mk( 0, 1'b0, 1'b0, S_RESET,     8'd0));
      tbl.push_back(mk(61, 1'b1, 1'b0, S_WAIT_LOCK, 8'd0));
      tbl.push_back(mk(65, 1'b0, 1'b0, S_STABLE,    8'd0));
      tbl.push_back(mk(67, 1'b0, 1'b0, S_STABLE,    8'd0));
      tbl.push_back(mk(68, 1'b0, 1'b0, S_RESET,     8'd1));
      tbl.push_back(mk(71, 1'b0, 1'b0, S_RESET,     8'd1));
      tbl.push_back(mk(72, 1'b1, 1'b0, S_WAIT_LOCK, 8'd1));
      tbl.push_back(mk(75, 1'b1, 1'b0, S_STABLE,    8'd1));
      tbl.push_back(mk(81, 1'b1, 1'b0, S_STABLE,    8'd1));
      tbl.push_back(mk(82, 1'b1, 1'b0, S_RUN,       8'd1));
      tbl.push_back(mk(90, 1'b0, 1'b0, S_RUN,       8'd1));
      tbl.push_back(mk(92, 1'b0, 1'b0, S_RUN,       8'd1));
      tbl.push_back(mk(93, 1'b0, 1'b0, S_RESET,     8'd0));
      run_table("retry");

      // Never locks: three reset pulses spaced by the timeout, then sticky fail.
      do_reset();
      for (int c = 0; c < FAIL_CYC + 6; c++) begin
         exp_pr = (c >= FAIL_CYC) ? 1'b1 : ((c % PERIOD) < RST_HOLD);
         check($sformatf("never_lock c%0d pll_rst", c), 32'(pll_rst), 32'(exp_pr));
         check($sformatf("never_lock c%0d fail", c), 32'(fail), 32'(c >= FAIL_CYC));
         if (c < FAIL_CYC && (c % PERIOD) == 0)
            check_outputs($sformatf("never_lock c%0d", c), S_RESET, 8'(c / PERIOD));
         if (c < FAIL_CYC && (c % PERIOD) == RST_HOLD)
            check_outputs($sformatf("never_lock c%0d", c), S_WAIT_LOCK, 8'(c / PERIOD));
         if (c == FAIL_CYC)
            check_outputs($sformatf("never_lock c%0d", c), S_FAIL, 8'(MAX_RETRIES));
         tick();
      end

      // Reconfigure out of fail, then again mid-qualification and mid-reset.
      tbl.push_back(mk(210, 1'b0, 1'b1, S_FAIL,      8'd2));
      tbl.push_back(mk(211, 1'b0, 1'b0, S_RESET,     8'd0));
      tbl.push_back(mk(214, 1'b0, 1'b0, S_RESET,     8'd0));
      tbl.push_back(mk(215, 1'b1, 1'b0, S_WAIT_LOCK, 8'd0));
      tbl.push_back(mk(218, 1'b1, 1'b0, S_STABLE,    8'd0));
      tbl.push_back(mk(220, 1'b1, 1'b1, S_STABLE,    8'd0));
      tbl.push_back(mk(221, 1'b1, 1'b0, S_RESET,     8'd0));
      tbl.push_back(mk(222, 1'b1, 1'b1, S_RESET,     8'd0));
      tbl.push_back(mk(223, 1'b1, 1'b0, S_RESET,     8'd0));
      tbl.push_back(mk(226, 1'b1, 1'b0, S_RESET,     8'd0));
      tbl.push_back(mk(227, 1'b1, 1'b0, S_WAIT_LOCK, 8'd0));
      tbl.push_back(mk(228, 1'b1, 1'b0, S_STABLE,    8'd0));
      tbl.push_back(mk(234, 1'b1, 1'b0, S_STABLE,    8'd0));
      tbl.push_back(mk(235, 1'b1, 1'b0, S_RUN,       8'd0));
      run_table("reconfig");

      // Synchronous reset asserted while qualifying lock.
      do_reset();
      while (cyc < 10) tick();
      pll_locked = 1'b1;
      while (cyc < 15) tick();
      check_outputs("rst_mid c15", S_STABLE, 8'd0);
      rst = 1'b1;
      tick();
      check_outputs("rst_mid asserted", S_RESET, 8'd0);
      rst = 1'b0;
      cyc = 0;
      while (cyc < 3) tick();
      check_outputs("rst_mid r3", S_RESET, 8'd0);
      tick();
      check_outputs("rst_mid r4", S_WAIT_LOCK, 8'd0);
      tick();
      check_outputs("rst_mid r5", S_STABLE, 8'd0);
      while (cyc < 11) tick();
      check_outputs("rst_mid r11", S_STABLE, 8'd0);
      tick();
      check_outputs("rst_mid r12", S_RUN, 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
